// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Honors laptop flow control (cts) at byte boundaries and force-terminates packets at MAX_PKT_BYTES.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int MAX_PKT_BYTES = 64,
  parameter int REQ_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   cts,
  output logic                   send_uart_data,
  output logic [7:0]             uart_data_tx,
  input  logic                   uart_data_sent,
  output logic                   grant_valid,
  output logic [REQ_IDX_W-1:0]   grant_id,
  output logic                   pkt_overflow,
  output logic [1:0]             fsm_state
);

  localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);

  // Handshake: a byte moves from requester i when req_valid[i] and req_ready[i] are both high
  // at a rising clock edge; req_ready is raised only for the owner, only in FETCH, only with cts high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [REQ_IDX_W-1:0]   grant_id_q, rr_ptr_q, pick_idx, rr_next;
  logic [REQ_IDX_W:0]     sum;
  logic                   pick_found;
  logic [2*NUM_REQ-1:0]   dbl_valid;
  logic [NUM_REQ-1:0]     rot_valid;
  logic [CNT_W-1:0]       byte_cnt_q;
  logic [7:0]             tx_byte_q, g_data;
  logic                   g_valid, g_last;
  logic                   last_q, ovf_q, pkt_overflow_q;
  logic                   accept, at_max;

  // Rotate the valid vector so bit k is requester (rr_ptr + k) mod NUM_REQ; lowest k wins.
  always_comb begin
    dbl_valid  = {req_valid, req_valid};
    rot_valid  = NUM_REQ'(dbl_valid >> rr_ptr_q);
    pick_found = |rot_valid;
    pick_idx   = '0;
    sum        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        sum = {1'b0, rr_ptr_q} + (REQ_IDX_W+1)'(k);
        if (sum >= (REQ_IDX_W+1)'(NUM_REQ)) sum = sum - (REQ_IDX_W+1)'(NUM_REQ);
        pick_idx = sum[REQ_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == REQ_IDX_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*8 +: 8];
      end
    end
  end

  assign at_max  = (byte_cnt_q == CNT_W'(MAX_PKT_BYTES - 1));
  assign rr_next = (grant_id_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE:  if (pick_found) state_d = FETCH;
      FETCH: begin
        if (g_valid && cts) begin
          accept    = 1'b1;
          req_ready = NUM_REQ'(1) << grant_id_q;
          state_d   = SEND;
        end
      end
      SEND:  if (uart_data_sent) state_d = last_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_id_q     <= '0;
      rr_ptr_q       <= '0;
      byte_cnt_q     <= '0;
      tx_byte_q      <= '0;
      last_q         <= 1'b0;
      ovf_q          <= 1'b0;
      pkt_overflow_q <= 1'b0;
    end else begin
      pkt_overflow_q <= 1'b0;
      if (state_q == IDLE && pick_found) begin
        grant_id_q <= pick_idx;
        byte_cnt_q <= '0;
      end
      if (accept) begin
        tx_byte_q  <= g_data;
        last_q     <= g_last | at_max;
        ovf_q      <= ~g_last & at_max;
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
      if (state_q == SEND && uart_data_sent && last_q) begin
        rr_ptr_q       <= rr_next;
        pkt_overflow_q <= ovf_q;
      end
    end
  end

  assign grant_valid    = (state_q != IDLE);
  assign send_uart_data = (state_q == SEND);
  assign uart_data_tx   = (state_q == SEND) ? tx_byte_q : 8'h00;
  assign grant_id       = grant_id_q;
  assign pkt_overflow   = pkt_overflow_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a timed transceiver model and a packet-level
// round-robin reference that predicts byte stream, grant order and overflow count.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int MAX_PKT = 64;
  localparam int IW      = 1;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 cts = 1'b1;
  logic                 send_uart_data;
  logic [7:0]           uart_data_tx;
  logic                 uart_data_sent = 1'b0;
  logic                 grant_valid;
  logic [IW-1:0]        grant_id;
  logic                 pkt_overflow;
  logic [1:0]           fsm_state;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_PKT_BYTES(MAX_PKT), .REQ_IDX_W(IW)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .cts(cts), .send_uart_data(send_uart_data),
    .uart_data_tx(uart_data_tx), .uart_data_sent(uart_data_sent), .grant_valid(grant_valid),
    .grant_id(grant_id), .pkt_overflow(pkt_overflow), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  int tests_run = 0;
  int tests_failed = 0;

  // requester sources, reference model state and expectations
  logic [8:0] src_q[NUM_REQ][$];
  logic [8:0] mdl_q[NUM_REQ][$];
  logic [7:0] exp_q[$];
  int         exp_gnt_q[$];
  int         exp_ovf = 0;
  int         mdl_ptr = 0;
  bit         cts_rand = 0;
  int         tc_delay = 10;

  // monitor state
  logic [7:0] mon_byte_q[$];
  int         mon_gnt_q[$];
  int         acc_cnt[NUM_REQ];
  int         ovf_cnt = 0, stab_err = 0, gv_err = 0, tc_cnt = 0;
  logic       prev_send = 0, prev_sent = 0, prev_gv = 0;
  logic [7:0] prev_tx = 0;
  logic [1:0] idle_state = 0, send_state = 0;

  // transceiver model + monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset_n || !send_uart_data) begin
      uart_data_sent = 1'b0;
      tc_cnt = 0;
    end else if (uart_data_sent) begin
      uart_data_sent = 1'b0;
      tc_cnt = 0;
    end else begin
      tc_cnt++;
      if (tc_cnt >= tc_delay) uart_data_sent = 1'b1;
    end
    if (send_uart_data && prev_send && !prev_sent && uart_data_tx !== prev_tx) stab_err++;
    if (send_uart_data && uart_data_sent) mon_byte_q.push_back(uart_data_tx);
    if (grant_valid && !prev_gv) mon_gnt_q.push_back(int'(grant_id));
    if (send_uart_data) send_state = fsm_state;
    if (reset_n && grant_valid !== (fsm_state != idle_state)) gv_err++;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) acc_cnt[i]++;
    if (pkt_overflow) ovf_cnt++;
    prev_send = send_uart_data;
    prev_sent = uart_data_sent;
    prev_tx   = uart_data_tx;
    prev_gv   = grant_valid;
  end

  // driver tasks
  task automatic drive_reqs();
    logic [8:0] head;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        head = src_q[i][0];
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = head[7:0];
        req_last[i] = head[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] acc;
    @(posedge clock);
    acc = req_ready;
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (cts_rand) cts = ($urandom_range(0, 3) != 0);
    drive_reqs();
    #1;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
    mdl_q[r].push_back({last, d});
  endtask

  task automatic push_rand_pkt(input int r, input int len);
    for (int i = 0; i < len; i++) push_byte(r, 8'($urandom_range(0, 255)), i == len - 1);
  endtask

  task automatic clear_exp();
    exp_q.delete();
    exp_gnt_q.delete();
    exp_ovf = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    mdl_ptr = 0;
    cts_rand = 0;
    cts = 1'b1;
    drive_reqs();
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  // Reference: whole packets served in round-robin order, each grant capped at MAX_PKT bytes.
  task automatic run_model();
    logic [8:0] b;
    int  sel, n;
    bit  any, stalled;
    stalled = 0;
    while (!stalled) begin
      any = 0;
      sel = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (mdl_ptr + k) % NUM_REQ;
        if (!any && mdl_q[c].size() > 0) begin any = 1; sel = c; end
      end
      if (!any) break;
      exp_gnt_q.push_back(sel);
      n = 0;
      do begin
        b = mdl_q[sel].pop_front();
        exp_q.push_back(b[7:0]);
        n++;
      end while (!b[8] && n < MAX_PKT && mdl_q[sel].size() > 0);
      if (b[8] || n == MAX_PKT) begin
        if (!b[8]) exp_ovf++;
        mdl_ptr = (sel + 1) % NUM_REQ;
      end else begin
        stalled = 1;
      end
    end
  endtask

  task automatic wait_bytes(input int target, input int budget, output bit ok);
    ok = (mon_byte_q.size() >= target);
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      ok = (mon_byte_q.size() >= target);
    end
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    idle_state = fsm_state;
    tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_valid got=%b exp=0", grant_valid); end
    tests_run++; if (send_uart_data !== 1'b0) begin tests_failed++; $display("FAIL reset_send got=%b exp=0", send_uart_data); end
    tests_run++; if (uart_data_tx !== 8'h00) begin tests_failed++; $display("FAIL reset_tx got=%h exp=00", uart_data_tx); end
    tests_run++; if (req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    tests_run++; if (pkt_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got=%b exp=0", pkt_overflow); end
    tests_run++; if (grant_id !== '0) begin tests_failed++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
  endtask

  task automatic test_single_packet();
    int b0, a0, s0, g0;
    bit ok;
    clear_exp();
    tc_delay = 10;
    b0 = mon_byte_q.size(); a0 = acc_cnt[0]; s0 = stab_err; g0 = gv_err;
    push_byte(0, 8'h59, 1'b0); push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
    run_model();
    wait_bytes(b0 + exp_q.size(), 400, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_timeout got=%0d exp=%0d bytes", mon_byte_q.size() - b0, exp_q.size()); end
    tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL single_grant_fall got=%b exp=0", grant_valid); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++;
      if (mon_byte_q.size() <= b0 + i || mon_byte_q[b0+i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, (mon_byte_q.size() > b0 + i) ? mon_byte_q[b0+i] : 8'hxx, exp_q[i]);
      end
    end
    tests_run++; if (acc_cnt[0] - a0 != 3) begin tests_failed++; $display("FAIL single_ready_pulses got=%0d exp=3", acc_cnt[0] - a0); end
    tests_run++; if (stab_err != s0) begin tests_failed++; $display("FAIL single_tx_stable got=%0d exp=0 changes", stab_err - s0); end
    tests_run++; if (send_state === idle_state || gv_err != g0) begin
      tests_failed++; $display("FAIL single_state_dbg send_state=%0d idle_state=%0d gv_err=%0d", send_state, idle_state, gv_err - g0);
    end
  endtask

  task automatic test_round_robin();
    int b0, g0;
    bit ok;
    apply_reset();
    clear_exp();
    tc_delay = 3;
    b0 = mon_byte_q.size(); g0 = mon_gnt_q.size();
    repeat (2) begin
      push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b1);
      push_byte(1, 8'hB0, 1'b0); push_byte(1, 8'hB1, 1'b1);
    end
    run_model();
    wait_bytes(b0 + exp_q.size(), 400, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr_timeout got=%0d exp=%0d bytes", mon_byte_q.size() - b0, exp_q.size()); end
    for (int i = 0; i < exp_gnt_q.size(); i++) begin
      tests_run++;
      if (mon_gnt_q.size() <= g0 + i || mon_gnt_q[g0+i] != exp_gnt_q[i]) begin
        tests_failed++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, (mon_gnt_q.size() > g0 + i) ? mon_gnt_q[g0+i] : -1, exp_gnt_q[i]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++;
      if (mon_byte_q.size() <= b0 + i || mon_byte_q[b0+i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL rr_byte[%0d] got=%h exp=%h", i, (mon_byte_q.size() > b0 + i) ? mon_byte_q[b0+i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_cts_hold();
    int b0, bad;
    bit ok;
    clear_exp();
    tc_delay = 4;
    cts = 1'b0;
    b0 = mon_byte_q.size();
    push_byte(1, 8'h5A, 1'b0); push_byte(1, 8'h5B, 1'b1);
    run_model();
    step(); step();
    bad = 0;
    repeat (50) begin
      if (grant_valid !== 1'b1 || grant_id !== 1'b1 || req_ready !== '0 || send_uart_data !== 1'b0) bad++;
      step();
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL cts_hold_stall got=%0d bad cycles exp=0", bad); end
    cts = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL cts_rise_ready got=%b exp=10", req_ready); end
    step();
    tests_run++; if (send_uart_data !== 1'b1 || uart_data_tx !== 8'h5A) begin
      tests_failed++; $display("FAIL cts_rise_send got=%b/%h exp=1/5a", send_uart_data, uart_data_tx);
    end
    wait_bytes(b0 + exp_q.size(), 200, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++;
      if (mon_byte_q.size() <= b0 + i || mon_byte_q[b0+i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL cts_hold_byte[%0d] got=%h exp=%h", i, (mon_byte_q.size() > b0 + i) ? mon_byte_q[b0+i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_cts_mid_send();
    int b0, b1, a0, bad;
    bit ok;
    clear_exp();
    tc_delay = 10;
    cts = 1'b1;
    b0 = mon_byte_q.size();
    push_byte(0, 8'h33, 1'b0); push_byte(0, 8'h44, 1'b1);
    run_model();
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      step();
      ok = (send_uart_data === 1'b1 && uart_data_tx === 8'h33);
    end
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL midsend_start got=%b/%h exp=1/33", send_uart_data, uart_data_tx); end
    cts = 1'b0;
    b1 = mon_byte_q.size();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (mon_byte_q.size() > b1) break;
      if (send_uart_data !== 1'b1) bad++;
    end
    tests_run++; if (bad != 0 || mon_byte_q.size() <= b1 || mon_byte_q[b1] !== 8'h33) begin
      tests_failed++; $display("FAIL midsend_complete got=%0d drops, %0d bytes exp=0 drops, byte 33", bad, mon_byte_q.size() - b1);
    end
    a0 = acc_cnt[0];
    bad = 0;
    repeat (20) begin
      step();
      if (req_ready !== '0 || send_uart_data !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0 || acc_cnt[0] != a0) begin
      tests_failed++; $display("FAIL midsend_hold got=%0d bad, %0d accepts exp=0,0", bad, acc_cnt[0] - a0);
    end
    cts = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL midsend_resume got=%b exp=01", req_ready); end
    wait_bytes(b0 + exp_q.size(), 200, ok);
    tests_run++; if (mon_byte_q.size() != b0 + 2 || mon_byte_q[b0+1] !== 8'h44) begin
      tests_failed++; $display("FAIL midsend_second got=%0d bytes exp=2 ending 44", mon_byte_q.size() - b0);
    end
  endtask

  task automatic test_random_traffic();
    int b0, g0, o0, errs;
    bit ok;
    apply_reset();
    repeat (3) begin
      clear_exp();
      tc_delay = $urandom_range(1, 5);
      b0 = mon_byte_q.size(); g0 = mon_gnt_q.size(); o0 = ovf_cnt;
      for (int r = 0; r < NUM_REQ; r++)
        repeat ($urandom_range(1, 4)) push_rand_pkt(r, $urandom_range(1, 6));
      run_model();
      cts_rand = 1;
      wait_bytes(b0 + exp_q.size(), 3000, ok);
      cts_rand = 0;
      cts = 1'b1;
      step(); step();
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand_timeout got=%0d exp=%0d bytes", mon_byte_q.size() - b0, exp_q.size()); end
      errs = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (mon_byte_q.size() <= b0 + i || mon_byte_q[b0+i] !== exp_q[i]) errs++;
      tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL rand_stream got=%0d wrong bytes exp=0 (of %0d)", errs, exp_q.size()); end
      errs = 0;
      for (int i = 0; i < exp_gnt_q.size(); i++)
        if (mon_gnt_q.size() <= g0 + i || mon_gnt_q[g0+i] != exp_gnt_q[i]) errs++;
      tests_run++; if (errs != 0 || mon_gnt_q.size() - g0 != exp_gnt_q.size()) begin
        tests_failed++; $display("FAIL rand_grants got=%0d grants, %0d wrong exp=%0d grants", mon_gnt_q.size() - g0, errs, exp_gnt_q.size());
      end
      tests_run++; if (ovf_cnt - o0 != exp_ovf) begin tests_failed++; $display("FAIL rand_overflow got=%0d exp=%0d", ovf_cnt - o0, exp_ovf); end
    end
  endtask

  task automatic test_overflow();
    int b0, g0, o0, errs;
    bit ok;
    apply_reset();
    clear_exp();
    tc_delay = 2;
    b0 = mon_byte_q.size(); g0 = mon_gnt_q.size(); o0 = ovf_cnt;
    for (int i = 0; i < 70; i++) push_byte(0, 8'($urandom_range(0, 255)), 1'b0);
    push_byte(1, 8'hB0, 1'b0); push_byte(1, 8'hB1, 1'b1);
    run_model();
    wait_bytes(b0 + exp_q.size(), 2000, ok);
    step(); step();
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_timeout got=%0d exp=%0d bytes", mon_byte_q.size() - b0, exp_q.size()); end
    tests_run++; if (ovf_cnt - o0 != exp_ovf) begin tests_failed++; $display("FAIL ovf_pulses got=%0d exp=%0d", ovf_cnt - o0, exp_ovf); end
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (mon_byte_q.size() <= b0 + i || mon_byte_q[b0+i] !== exp_q[i]) errs++;
    tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL ovf_stream got=%0d wrong bytes exp=0", errs); end
    for (int i = 0; i < exp_gnt_q.size(); i++) begin
      tests_run++;
      if (mon_gnt_q.size() <= g0 + i || mon_gnt_q[g0+i] != exp_gnt_q[i]) begin
        tests_failed++; $display("FAIL ovf_grant[%0d] got=%0d exp=%0d", i, (mon_gnt_q.size() > g0 + i) ? mon_gnt_q[g0+i] : -1, exp_gnt_q[i]);
      end
    end
    tests_run++; if (grant_valid !== 1'b1 || grant_id !== 1'b0 || req_ready !== '0) begin
      tests_failed++; $display("FAIL ovf_tail_stall got=%b/%0d/%b exp=1/0/00", grant_valid, grant_id, req_ready);
    end
  endtask

  task automatic test_reset_mid_send();
    int b0, g0, a0, bad;
    bit ok;
    apply_reset();
    clear_exp();
    tc_delay = 8;
    for (int i = 0; i < 8; i++) push_byte(0, 8'(8'h80 + i), i == 7);
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      step();
      ok = (send_uart_data === 1'b1);
    end
    #1;
    reset_n = 1'b0;
    #1;
    tests_run++; if (!ok || send_uart_data !== 1'b0 || uart_data_tx !== 8'h00 || grant_valid !== 1'b0 || req_ready !== '0) begin
      tests_failed++; $display("FAIL rst_mid_outputs got=%b/%h/%b/%b exp=0/00/0/00", send_uart_data, uart_data_tx, grant_valid, req_ready);
    end
    for (int i = 0; i < NUM_REQ; i++) begin src_q[i].delete(); mdl_q[i].delete(); end
    drive_reqs();
    a0 = acc_cnt[0];
    bad = 0;
    repeat (3) begin
      step();
      if (send_uart_data !== 1'b0 || req_ready !== '0) bad++;
    end
    tests_run++; if (bad != 0 || acc_cnt[0] != a0) begin tests_failed++; $display("FAIL rst_mid_quiet got=%0d bad exp=0", bad); end
    reset_n = 1'b1;
    mdl_ptr = 0;
    clear_exp();
    tc_delay = 3;
    b0 = mon_byte_q.size(); g0 = mon_gnt_q.size();
    push_byte(0, 8'h11, 1'b1); push_byte(1, 8'h22, 1'b1);
    run_model();
    wait_bytes(b0 + exp_q.size(), 200, ok);
    tests_run++; if (mon_gnt_q.size() <= g0 || mon_gnt_q[g0] != exp_gnt_q[0]) begin
      tests_failed++; $display("FAIL rst_mid_first_grant got=%0d exp=%0d", (mon_gnt_q.size() > g0) ? mon_gnt_q[g0] : -1, exp_gnt_q[0]);
    end
    tests_run++; if (!ok || mon_byte_q[b0] !== exp_q[0] || mon_byte_q[b0+1] !== exp_q[1]) begin
      tests_failed++; $display("FAIL rst_mid_stream got=%0d bytes exp=%h %h", mon_byte_q.size() - b0, exp_q[0], exp_q[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_cts_hold();
    test_cts_mid_send();
    test_random_traffic();
    test_overflow();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (send_uart_data / uart_data_tx / uart_data_sent) among NUM_REQ byte-stream requesters, e.g. the face-result queue drain and a status/heartbeat generator.
- Arbitration is packet-atomic round-robin. Once a requester is granted, it owns the transmitter until its last byte is sent.
- Honors laptop flow control (CTS): a new byte is never started while the laptop cannot receive.
- Sits between the result producers and uart_tcvr.

Parameters:
- NUM_REQ, 2, number of requesters (2..8); index 0 has the highest priority after reset.
- MAX_PKT_BYTES, 64, maximum bytes per grant; longer packets are force-terminated.
- REQ_IDX_W, $clog2(NUM_REQ) (minimum 1), width of the grant index.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  marks the final byte of a packet; sampled with req_valid.
- req_ready  output  NUM_REQ  one-hot byte-accept pulse to the granted requester.
- cts  input  1  laptop can receive (uart_cts).
- send_uart_data  output  1  level request to uart_tcvr.
- uart_data_tx  output  8  byte to uart_tcvr.
- uart_data_sent  input  1  single-cycle completion pulse from uart_tcvr.
- grant_valid  output  1  a requester currently owns the transmitter.
- grant_id  output  REQ_IDX_W  index of the owning requester.
- pkt_overflow  output  1  one-cycle pulse when a packet is force-terminated at MAX_PKT_BYTES.

Behaviour:
- Clock and reset:
  - One clock, clock.
  - reset_n is asynchronous and active-low.
- Reset values:
  - State is IDLE; rr_ptr=0; byte_cnt=0; tx_byte=0.
  - All outputs are 0.
  - Reset mid-packet aborts immediately: send_uart_data drops asynchronously and no further req_ready is issued.
- States: IDLE, FETCH, SEND.
- IDLE:
  - Outputs: grant_valid=0, req_ready=0, send_uart_data=0.
  - If any req_valid is set, select the first index i at or after rr_ptr (mod NUM_REQ) with req_valid[i]=1.
  - Register grant_id=i, set byte_cnt=0, and go to FETCH next cycle.
  - Arbitration latency: one cycle from req_valid to grant_valid.
- FETCH:
  - grant_valid=1.
  - req_ready[grant_id] = req_valid[grant_id] & cts (combinational); all other req_ready bits are 0.
  - On accept:
    - tx_byte <= the granted requester's byte.
    - last_q <= req_last[grant_id] | (byte_cnt==MAX_PKT_BYTES-1).
    - ovf_q <= ~req_last[grant_id] & (byte_cnt==MAX_PKT_BYTES-1).
    - byte_cnt increments.
    - Go to SEND.
  - Stall with no timeout while req_valid[grant_id]=0 or cts=0; the grant is held.
  - Other requesters are never served while a grant is held.
- SEND:
  - grant_valid=1; send_uart_data=1; uart_data_tx=tx_byte, stable for the whole state.
  - cts is ignored mid-byte.
  - On uart_data_sent:
    - If last_q: rr_ptr <= (grant_id+1) mod NUM_REQ; pkt_overflow pulses for one cycle if ovf_q; go to IDLE.
    - Otherwise go to FETCH.
  - send_uart_data deasserts in the cycle after the pulse.
- uart_data_tx is 0 whenever the state is not SEND.
- Byte throughput: accept cycle t, send_uart_data high at t+1; minimum 2 cycles between the sent pulse and the next send_uart_data.
- uart_data_sent outside SEND is ignored.
- req_data / req_last of non-granted requesters are don't-care.
- A requester dropping req_valid mid-packet keeps its grant (stall); packets are never interleaved.
- Round-robin: the just-served requester gets the lowest priority for the next arbitration. With all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- Single-byte packet (req_last on the first byte) is legal.
- grant_id and grant_valid change only on IDLE→FETCH and SEND→IDLE transitions.

Test Plan:
- Single requester 0 sends a 3-byte packet 0x59,0x01,0x02 (last on 0x02), cts=1, tcvr model pulses sent 10 cycles after each request:
  - exactly 3 req_ready[0] pulses;
  - uart_data_tx sequence 0x59,0x01,0x02, each stable while send_uart_data=1;
  - grant_valid falls the cycle after the third sent pulse.
- Both requesters continuously valid with 2-byte packets (req0: 0xA0,0xA1; req1: 0xB0,0xB1):
  - grant order 0,1,0,1;
  - bytes never interleaved; the observed stream is A0 A1 B0 B1 A0 A1….
- cts held 0 for 50 cycles while requester 1 is valid:
  - grant_valid=1, grant_id=1, req_ready=0, send_uart_data=0 throughout;
  - the first byte is accepted in the cycle cts rises.
- cts drops during SEND of byte 0x33:
  - send_uart_data stays 1 and 0x33 completes;
  - the next byte is not accepted until cts returns to 1.
- Requester 0 streams 70 bytes with no req_last (MAX_PKT_BYTES=64):
  - after the 64th sent pulse pkt_overflow pulses once and the grant releases;
  - requester 1, if valid, is granted next.
- reset_n asserted during SEND:
  - outputs go to 0 immediately;
  - after release, rr_ptr=0 and requester 0 wins a simultaneous request.
